// File: rtl/loop_mux.sv
// Loop-instruction decoder: holds the program's 8-entry loop table and decodes
// the selected entry combinationally alongside the instruction's flag bits.
module loop_mux #(
    parameter int LOG_LOOP_CNT = 3,
    parameter int ITER_W       = 18,
    parameter int JUMP_W       = 6
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               load,
    input  logic [(1<<LOG_LOOP_CNT)*(ITER_W+JUMP_W)-1:0]       in,
    input  logic [LOG_LOOP_CNT-1:0]                            addr,
    input  logic                                               independent,
    input  logic                                               new_loop,
    output logic                                               is_new_loop,
    output logic                                               is_independent,
    output logic [JUMP_W-1:0]                                  jump_amount,
    output logic [ITER_W-1:0]                                  iteration_count,
    output logic [LOG_LOOP_CNT-1:0]                            name,
    output logic                                               zero_iter_error
);
    localparam int ENT_W = ITER_W + JUMP_W;
    localparam int TBL_W = (1 << LOG_LOOP_CNT) * ENT_W;

    logic [TBL_W-1:0] table_q, table_d;
    logic [ENT_W-1:0] entry;

    always_comb begin
        table_d = table_q;
        if (load) table_d = in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) table_q <= '0;
        else        table_q <= table_d;
    end

    // Fixed 8-way select keeps the read path a balanced mux tree.
    always_comb begin
        entry = '0;
        case (addr)
            3'd0:    entry = table_q[0*ENT_W +: ENT_W];
            3'd1:    entry = table_q[1*ENT_W +: ENT_W];
            3'd2:    entry = table_q[2*ENT_W +: ENT_W];
            3'd3:    entry = table_q[3*ENT_W +: ENT_W];
            3'd4:    entry = table_q[4*ENT_W +: ENT_W];
            3'd5:    entry = table_q[5*ENT_W +: ENT_W];
            3'd6:    entry = table_q[6*ENT_W +: ENT_W];
            3'd7:    entry = table_q[7*ENT_W +: ENT_W];
            default: entry = '0;
        endcase
    end

    always_comb begin
        iteration_count = entry[ITER_W-1:0];
        jump_amount     = entry[ENT_W-1:ITER_W];
        is_new_loop     = new_loop;
        is_independent  = independent & new_loop;
        name            = addr;
        zero_iter_error = new_loop & (entry[ITER_W-1:0] == '0);
    end
endmodule

// File: tb/tb_loop_mux.sv
// Randomised scoreboard bench for loop_mux with an array-based table model.
module tb_loop_mux;
    logic         clk = 1'b0;
    logic         reset, load, independent, new_loop;
    logic [191:0] in;
    logic [2:0]   addr;
    logic         is_new_loop, is_independent, zero_iter_error;
    logic [5:0]   jump_amount;
    logic [17:0]  iteration_count;
    logic [2:0]   name;

    typedef struct {
        logic        nl, ind, zerr;
        logic [5:0]  jmp;
        logic [17:0] cnt;
        logic [2:0]  nm;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;
    logic [17:0] mcnt[8], pcnt[8];
    logic [5:0]  mjmp[8], pjmp[8];
    logic        done = 1'b0;

    loop_mux dut (
        .clk(clk), .reset(reset), .load(load), .in(in), .addr(addr),
        .independent(independent), .new_loop(new_loop),
        .is_new_loop(is_new_loop), .is_independent(is_independent),
        .jump_amount(jump_amount), .iteration_count(iteration_count),
        .name(name), .zero_iter_error(zero_iter_error)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string f, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s actual %0d required %0d", tag, f, act, exp);
        end
    endtask

    // Monitor: one sample per cycle, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.tag, "iteration_count", int'(iteration_count), int'(e.cnt));
                cmp(e.tag, "jump_amount", int'(jump_amount), int'(e.jmp));
                cmp(e.tag, "name", int'(name), int'(e.nm));
                cmp(e.tag, "is_new_loop", int'(is_new_loop), int'(e.nl));
                cmp(e.tag, "is_independent", int'(is_independent), int'(e.ind));
                cmp(e.tag, "zero_iter_error", int'(zero_iter_error), int'(e.zerr));
            end
        end
    end

    function automatic logic [191:0] pack_pending();
        logic [191:0] v = '0;
        for (int k = 0; k < 8; k++) v[k*24 +: 24] = {pjmp[k], pcnt[k]};
        return v;
    endfunction

    // Drive one instruction for one cycle; the model table updates at the edge.
    task automatic step(input string tag, input logic rst, input logic ld,
                        input logic [2:0] a, input logic ind, input logic nl);
        exp_t e;
        reset = rst; load = ld; in = pack_pending();
        addr = a; independent = ind; new_loop = nl;
        if (!rst) for (int k = 0; k < 8; k++) begin mcnt[k] = '0; mjmp[k] = '0; end
        e.tag  = tag;
        e.cnt  = mcnt[a];
        e.jmp  = mjmp[a];
        e.nm   = a;
        e.nl   = nl;
        e.ind  = ind && nl;
        e.zerr = nl && (mcnt[a] == 0);
        sb.push_back(e);
        @(negedge clk);
        if (rst && ld) for (int k = 0; k < 8; k++) begin mcnt[k] = pcnt[k]; mjmp[k] = pjmp[k]; end
    endtask

    task automatic rand_pending();
        for (int k = 0; k < 8; k++) begin
            pcnt[k] = ($urandom_range(0, 3) == 0) ? 18'd0 : 18'($urandom);
            pjmp[k] = 6'($urandom);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin mcnt[k] = '0; mjmp[k] = '0; pcnt[k] = '0; pjmp[k] = '0; end
        reset = 1'b0; load = 1'b0; in = '0; addr = '0; independent = 1'b0; new_loop = 1'b0;
        @(negedge clk);
        step("reset_state", 1'b0, 1'b0, 3'd5, 1'b1, 1'b1);

        // Load/select sweep
        for (int k = 0; k < 8; k++) begin pcnt[k] = 18'(100 + k); pjmp[k] = 6'(k + 1); end
        step("load_sweep", 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
        for (int a = 0; a < 8; a++) step("sweep", 1'b1, 1'b0, 3'(a), 1'b0, 1'b1);

        // Field boundaries
        pcnt[7] = 18'h3FFFF; pjmp[7] = 6'h3F; pcnt[0] = 18'h00001; pjmp[0] = 6'h00;
        step("load_bound", 1'b1, 1'b1, 3'd1, 1'b0, 1'b1);
        step("bound7", 1'b1, 1'b0, 3'd7, 1'b0, 1'b1);
        step("bound0", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        step("bound6", 1'b1, 1'b0, 3'd6, 1'b0, 1'b1);

        // Flag decode on entry 2, with its count zeroed
        pcnt[2] = 18'd0;
        step("load_zero2", 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        step("flag_start", 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);
        step("flag_end", 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);

        // Same-cycle load: old value before the edge, new after, then hold
        pcnt[3] = 18'd10;
        step("load_10", 1'b1, 1'b1, 3'd3, 1'b0, 1'b1);
        pcnt[3] = 18'd20;
        step("same_cyc_old", 1'b1, 1'b1, 3'd3, 1'b0, 1'b1);
        pcnt[3] = 18'd30;
        step("same_cyc_new", 1'b1, 1'b0, 3'd3, 1'b0, 1'b1);
        step("hold", 1'b1, 1'b0, 3'd3, 1'b0, 1'b1);

        // Zero-count error on entry 4
        pcnt[4] = 18'd0;
        step("load_zero4", 1'b1, 1'b1, 3'd3, 1'b0, 1'b1);
        step("zerr_start", 1'b1, 1'b0, 3'd4, 1'b0, 1'b1);
        step("zerr_end", 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            rand_pending();
            step("random", 1'b1, 1'($urandom_range(0, 2) == 0), 3'($urandom),
                 1'($urandom), 1'($urandom));
        end

        // Mid-run reset with load asserted, then release without loading
        rand_pending();
        step("rst_async", 1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
        step("rst_hold", 1'b0, 1'b1, 3'd7, 1'b1, 1'b1);
        step("rst_release", 1'b1, 1'b0, 3'd5, 1'b0, 1'b1);
        step("post_reload", 1'b1, 1'b1, 3'd2, 1'b0, 1'b1);
        for (int a = 0; a < 8; a++) step("post_sweep", 1'b1, 1'b0, 3'(a), 1'b1, 1'b1);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d pending required 0", sb.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        if (!done) begin
            $display("FAIL timeout actual running required finished");
            $fatal(1);
        end
    end
endmodule

// File: doc/loop_mux.md
Name: loop_mux

Overview:
- Loop-instruction decoder for the control unit.
- Holds the program's loop read-only table: 8 entries, each with an iteration count and a jump amount.
- Selects one entry by the 3-bit loop address in the raw instruction and emits a decoded loop instruction (new/end flag, independence flag, jump amount, iteration count, loop name).
- Table is loaded once per program during program preparation; decode is combinational from the stored table so the control unit can decode in the same cycle as fetch.

Parameters:
- LOG_LOOP_CNT, 3, log2 of table entries (8 entries).
- ITER_W, 18, iteration-count width.
- JUMP_W, 6, jump-amount width.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous reset, active-low (asserted at 0).
- load  input  1  capture `in` into the table on the rising clk edge.
- in  input  8*(ITER_W+JUMP_W)=192  loop ro_data; entry k at in[k*24 +: 24].
- addr  input  3  loop table index, instruction bits [4:6].
- independent  input  1  instruction bit [2]; independent-iteration flag for start-loop instructions.
- new_loop  input  1  instruction bit [3]; 1 = start loop, 0 = end loop.
- is_new_loop  output  1  decoded start/end flag.
- is_independent  output  1  decoded independence flag.
- jump_amount  output  6  backward jump distance for the loop end.
- iteration_count  output  18  total iterations.
- name  output  3  loop name (stack variable index).
- zero_iter_error  output  1  start-loop selects an entry with iteration_count 0.

Behaviour:
- Table register: 192 bits.
  - reset=0 clears it to all zeros immediately, independent of clk.
  - On rising clk with reset=1 and load=1, table <= in.
  - Otherwise the table holds.
- Entry layout, entry k = table[k*24 +: 24]:
  - iteration_count = entry[17:0].
  - jump_amount = entry[23:18].
- Outputs are purely combinational from the table register and the current addr/independent/new_loop. Zero-cycle latency from addr to outputs.
- Decoded fields:
  - is_new_loop = new_loop.
  - is_independent = independent AND new_loop (forced 0 for end-loop instructions).
  - name = addr.
  - jump_amount and iteration_count come from table entry addr, regardless of new_loop.
  - zero_iter_error = new_loop AND (iteration_count == 0).
- Load and decode in the same cycle: outputs reflect the old table until the clock edge, then the new table. No bypass.
- During reset assertion the table is zero, so outputs are:
  - iteration_count 0, jump_amount 0.
  - is_new_loop, is_independent and name follow the inputs.
  - zero_iter_error = new_loop.
- Reset released mid-operation: the table stays zero until the next load.
- No X propagation: all 8 addr values are valid selections; every bit of every output is defined for all input combinations.
- The mux is built as an explicit 8-way case select, not a variable part-select.
- No other state. Behaviour is width-exact: no truncation or sign extension.

Test Plan:
- Reset: drive reset=0 mid-simulation with random `in` and load=1 -> table clears asynchronously; addr=5, new_loop=1 gives iteration_count=0, jump_amount=0, zero_iter_error=1.
- Load/select:
  - Load entries k with iteration_count=100+k, jump_amount=k+1.
  - Sweep addr 0..7 with new_loop=1 -> iteration_count=100+addr, jump_amount=addr+1, name=addr, zero_iter_error=0.
- Field boundaries: entry 7 = {6'h3F, 18'h3FFFF}, entry 0 = {6'h00, 18'h00001} -> addr=7 gives jump 63 / count 262143; addr=0 gives jump 0 / count 1. No cross-entry bleed.
- Flag decode, addr=2:
  - independent=1, new_loop=1 -> is_independent=1, is_new_loop=1.
  - independent=1, new_loop=0 -> is_independent=0, is_new_loop=0, zero_iter_error=0 even if count is 0.
- Same-cycle load:
  - Table entry 3 count=10; present in with entry 3 count=20, load=1, addr=3.
  - Before the edge the output is 10; after the edge it is 20.
  - With load=0 the next cycle, the output stays 20 despite `in` changing.
- Zero-count error: load entry 4 count=0, addr=4, new_loop=1 -> zero_iter_error=1; new_loop=0 -> 0.
